// File: rtl/barret_for_2689.sv
// rtl/barret_for_2689.sv - registered Barrett reduction of a 23-bit operand modulo 2689
module barret_for_2689 #(
    parameter int Q = 2689,
    parameter int K = 24,
    parameter int M = 6239
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] din_a,
    output logic [11:0] dout_r
);

    localparam logic [35:0] M36 = 36'(M);
    localparam logic [23:0] Q24 = 24'(Q);
    localparam logic [13:0] Q14 = 14'(Q);

    logic [35:0] prod;
    logic [35:0] prod_shift;
    logic [11:0] qe;
    logic [23:0] qe_q;
    logic [23:0] diff;
    logic [13:0] r0;
    logic [13:0] r1;
    logic [13:0] r2;

    // Full 36-bit product so the shift sees every bit of din_a * M.
    assign prod       = {13'd0, din_a} * M36;
    assign prod_shift = prod >> K;
    assign qe         = prod_shift[11:0];
    assign qe_q       = {12'd0, qe} * Q24;

    // qe undershoots the true quotient by at most two, so r0 fits in 14 bits.
    assign diff = {1'b0, din_a} - qe_q;
    assign r0   = diff[13:0];
    assign r1   = (r0 >= Q14) ? (r0 - Q14) : r0;
    assign r2   = (r1 >= Q14) ? (r1 - Q14) : r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= 12'd0;
        end else begin
            dout_r <= r2[11:0];
        end
    end

endmodule

// File: tb/tb_barret_for_2689.sv
// tb/tb_barret_for_2689.sv - directed self-checking bench for barret_for_2689
module tb_barret_for_2689;

    logic        clk;
    logic        rst_n;
    logic [22:0] din_a;
    logic [11:0] dout_r;

    int checks;
    int errors;

    barret_for_2689 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din_a (din_a),
        .dout_r(dout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        din_a = 23'd1234;
        repeat (2) @(negedge clk);
        checks++;
        if (dout_r !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: dout_r=%0d expected=0", dout_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_r !== 12'd1234) begin
            errors++;
            $display("FAIL reset_release_first_edge: dout_r=%0d expected=1234", dout_r);
        end
    endtask

    task automatic test_sweep();
        int bad;
        bad = 0;
        for (int i = 0; i < 2689; i++) begin
            din_a = 23'(i);
            @(negedge clk);
            checks++;
            if (dout_r !== 12'(i)) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL sweep din_a=%0d: dout_r=%0d expected=%0d", i, dout_r, i);
            end
        end
    endtask

    task automatic run_table(input string name, input int n,
                             input logic [22:0] vin [16], input logic [11:0] vexp [16]);
        for (int i = 0; i < n; i++) begin
            din_a = vin[i];
            @(negedge clk);
            checks++;
            if (dout_r !== vexp[i]) begin
                errors++;
                $display("FAIL %s din_a=%0d: dout_r=%0d expected=%0d", name, vin[i], dout_r, vexp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [22:0] vin [16];
        logic [11:0] vexp [16];
        vin  = '{default: '0};
        vexp = '{default: '0};
        vin[0] = 23'd2689;    vexp[0] = 12'd0;
        vin[1] = 23'd5378;    vexp[1] = 12'd0;
        vin[2] = 23'd5377;    vexp[2] = 12'd2688;
        vin[3] = 23'd7230721; vexp[3] = 12'd0;
        vin[4] = 23'd8067;    vexp[4] = 12'd0;
        vin[5] = 23'd8066;    vexp[5] = 12'd2688;
        run_table("wrap", 6, vin, vexp);
    endtask

    task automatic test_top();
        logic [22:0] vin [16];
        logic [11:0] vexp [16];
        vin  = '{default: '0};
        vexp = '{default: '0};
        // 8388607 = 2689 * 3119 + 1616
        vin[0] = 23'd8388607; vexp[0] = 12'd1616;
        vin[1] = 23'd7230720; vexp[1] = 12'd2688;
        vin[2] = 23'd0;       vexp[2] = 12'd0;
        vin[3] = 23'd2688;    vexp[3] = 12'd2688;
        run_table("top", 4, vin, vexp);
    endtask

    task automatic test_back_to_back();
        logic [22:0] vin [16];
        logic [11:0] vexp [16];
        vin  = '{default: '0};
        vexp = '{default: '0};
        vin[0] = 23'd10000;   vexp[0] = 12'd1933;
        vin[1] = 23'd1000000; vexp[1] = 12'd2381;
        vin[2] = 23'd4194304; vexp[2] = 12'd2153;
        vin[3] = 23'd123456;  vexp[3] = 12'd2451;
        vin[4] = 23'd8388607; vexp[4] = 12'd1616;
        vin[5] = 23'd1;       vexp[5] = 12'd1;
        vin[6] = 23'd10000;   vexp[6] = 12'd1933;
        vin[7] = 23'd2689;    vexp[7] = 12'd0;
        run_table("back_to_back", 8, vin, vexp);
    endtask

    task automatic test_midstream_reset();
        din_a = 23'd10000;
        @(negedge clk);
        checks++;
        if (dout_r !== 12'd1933) begin
            errors++;
            $display("FAIL midreset_pre: dout_r=%0d expected=1933", dout_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout_r !== 12'd0) begin
            errors++;
            $display("FAIL midreset_async_clear: dout_r=%0d expected=0", dout_r);
        end
        @(negedge clk);
        checks++;
        if (dout_r !== 12'd0) begin
            errors++;
            $display("FAIL midreset_held: dout_r=%0d expected=0", dout_r);
        end
        din_a = 23'd1000000;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_r !== 12'd2381) begin
            errors++;
            $display("FAIL midreset_release: dout_r=%0d expected=2381", dout_r);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din_a  = '0;
        test_reset();
        test_sweep();
        test_wrap();
        test_top();
        test_back_to_back();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
